// File: rtl/seg_display_decoder_if.sv
// seg_display_decoder_if: scanned seg/an bus in, decoded 4-digit frame and error strobes out
interface seg_display_decoder_if;
  logic [6:0] seg;
  logic [3:0] an;
  logic [15:0] digits;
  logic [3:0] blank;
  logic frame_valid;
  logic dec_err;
  logic an_err;
  modport master (output seg, an, input digits, blank, frame_valid, dec_err, an_err);
  modport slave (input seg, an, output digits, blank, frame_valid, dec_err, an_err);
endinterface

// File: rtl/seg_display_decoder.sv
// seg_display_decoder: samples a multiplexed 7-segment bus, decodes settled slots to BCD and emits 4-digit frames
module seg_display_decoder #(
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int AN_ACTIVE_LOW = 1,
  parameter int SETTLE_CYCLES = 2
) (
  input logic clk,
  input logic reset,
  seg_display_decoder_if.slave bus
);
  logic [6:0] seg_n;
  logic [3:0] an_n;
  logic [10:0] cur, prev;
  logic [3:0] cnt, seen, shadow_blank;
  logic [15:0] shadow;
  logic captured, same, cap, none, one, is_blank, bad;
  logic [3:0] nib;
  always_comb begin
    seg_n = SEG_ACTIVE_LOW != 0 ? ~bus.seg : bus.seg;
    an_n = AN_ACTIVE_LOW != 0 ? ~bus.an : bus.an;
    cur = {an_n, seg_n};
    same = cur == prev;
    cap = same && cnt == 4'(SETTLE_CYCLES - 1) && !captured;
    none = an_n == 4'd0;
    one = !none && (an_n & (an_n - 4'd1)) == 4'd0;
  end
  always_comb begin
    nib = 4'hE;
    bad = 1'b0;
    is_blank = 1'b0;
    case (seg_n)
      7'h3F: nib = 4'd0;
      7'h06: nib = 4'd1;
      7'h5B: nib = 4'd2;
      7'h4F: nib = 4'd3;
      7'h66: nib = 4'd4;
      7'h6D: nib = 4'd5;
      7'h7D: nib = 4'd6;
      7'h07: nib = 4'd7;
      7'h7F: nib = 4'd8;
      7'h6F: nib = 4'd9;
      7'h00: begin nib = 4'd0; is_blank = 1'b1; end
      default: bad = 1'b1;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      prev <= '0;
      cnt <= '0;
      captured <= 1'b0;
      seen <= '0;
      shadow <= '0;
      shadow_blank <= '0;
      bus.digits <= '0;
      bus.blank <= '0;
      bus.frame_valid <= 1'b0;
      bus.dec_err <= 1'b0;
      bus.an_err <= 1'b0;
    end else begin
      prev <= cur;
      cnt <= same ? (cnt == 4'hF ? cnt : cnt + 4'd1) : 4'd0;
      captured <= same && (captured || cap);
      bus.frame_valid <= seen == 4'hF;
      bus.dec_err <= cap && one && bad;
      bus.an_err <= cap && !none && !one;
      if (seen == 4'hF) begin
        bus.digits <= shadow;
        bus.blank <= shadow_blank;
      end
      // a capture on the completion edge already belongs to the next frame
      seen <= (seen == 4'hF ? 4'd0 : seen) | (cap && one ? an_n : 4'd0);
      for (int i = 0; i < 4; i++)
        if (cap && one && an_n[i]) begin
          shadow[4*i +: 4] <= nib;
          shadow_blank[i] <= is_blank;
        end
    end
  end
endmodule
